// File: rtl/plot_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | plot_fifo: clips plot requests to 160x120, buffers survivors for the VGA |
// | write port, and delays done until every buffered pixel is written.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module plot_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_plot,
  input  logic       in_done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  input  logic       vga_ready,
  output logic       done,
  output logic       full,
  output logic [7:0] clip_count,
  output logic [7:0] drop_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_FILLING = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t          r_state;
  logic [17:0]     r_mem [DEPTH];
  logic [c_aw-1:0] r_wr;
  logic [c_aw-1:0] r_rd;
  logic [c_aw:0]   r_count;
  logic [7:0]      r_clip;
  logic [7:0]      r_drop;
  logic            r_seen;
  logic            r_done;

  logic            w_on_screen;
  logic            w_pop;
  logic            w_slot;
  logic            w_push;
  logic            w_clip;
  logic            w_drop;
  logic [c_aw:0]   w_count_next;
  logic [17:0]     w_head;

  assign w_on_screen = (in_x < 8'd160) && (in_y < 7'd120);
  assign w_pop       = vga_plot && vga_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_slot      = (r_count != c_depth) || w_pop;
  assign w_push      = in_plot && w_on_screen && w_slot;
  assign w_clip      = in_plot && !w_on_screen;
  assign w_drop      = in_plot && w_on_screen && !w_slot;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (c_aw + 1)'(1);
      2'b01:   w_count_next = r_count - (c_aw + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_state <= S_EMPTY;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_clip  <= 8'd0;
      r_drop  <= 8'd0;
      r_seen  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + c_aw'(1);
      if (w_pop)  r_rd <= r_rd + c_aw'(1);
      r_count <= w_count_next;
      if (w_count_next == '0)
        r_state <= S_EMPTY;
      else if (w_count_next == c_depth)
        r_state <= S_FULL;
      else
        r_state <= S_FILLING;
      if (w_clip && r_clip != 8'hFF) r_clip <= r_clip + 8'd1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      // done uses the pre-edge view so it lands one edge after the last pop.
      r_done <= r_done || (r_seen && (r_state == S_EMPTY) && !in_plot);
      r_seen <= r_seen || in_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && w_push)
      r_mem[r_wr] <= {in_x, in_y, in_colour};
  end

  assign w_head     = r_mem[r_rd];
  assign vga_plot   = (r_state != S_EMPTY);
  assign full       = (r_state == S_FULL);
  assign vga_x      = vga_plot ? w_head[17:10] : 8'd0;
  assign vga_y      = vga_plot ? w_head[9:3]   : 7'd0;
  assign vga_colour = vga_plot ? w_head[2:0]   : 3'd0;
  assign done       = r_done;
  assign clip_count = r_clip;
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_plot_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_plot_fifo: directed bench for plot_fifo with a queue-based model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_plot_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_x = 8'd0;
  logic [6:0] in_y = 7'd0;
  logic [2:0] in_colour = 3'd0;
  logic       in_plot = 1'b0;
  logic       in_done = 1'b0;
  logic       vga_ready = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;
  logic       full;
  logic [7:0] clip_count;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  plot_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_done(in_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .vga_ready(vga_ready),
    .done(done), .full(full),
    .clip_count(clip_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pixels plus saturating tallies.
  logic [17:0] m_q[$];
  int          m_clip = 0;
  int          m_drop = 0;
  bit          m_seen = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk) begin
    bit pop;
    bit onscr;
    if (!rst_n || clear) begin
      m_q.delete();
      m_clip = 0; m_drop = 0; m_seen = 1'b0; m_done = 1'b0;
    end else begin
      onscr = (in_x < 160) && (in_y < 120);
      pop   = (m_q.size() > 0) && vga_ready;
      m_done = m_done || (m_seen && m_q.size() == 0 && !in_plot);
      m_seen = m_seen || in_done;
      if (in_plot && !onscr && m_clip < 255) m_clip++;
      if (in_plot && onscr && !(m_q.size() < DEPTH || pop) && m_drop < 255) m_drop++;
      if (pop) void'(m_q.pop_front());
      if (in_plot && onscr && m_q.size() < DEPTH) m_q.push_back({in_x, in_y, in_colour});
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int ex, ey, ec;
      ex = 0; ey = 0; ec = 0;
      if (m_q.size() > 0) begin
        ex = int'(m_q[0][17:10]); ey = int'(m_q[0][9:3]); ec = int'(m_q[0][2:0]);
      end
      check("m_plot", int'(vga_plot), int'(m_q.size() > 0));
      check("m_x", int'(vga_x), ex);
      check("m_y", int'(vga_y), ey);
      check("m_colour", int'(vga_colour), ec);
      check("m_full", int'(full), int'(m_q.size() == DEPTH));
      check("m_clip", int'(clip_count), m_clip);
      check("m_drop", int'(drop_count), m_drop);
      check("m_done", int'(done), int'(m_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input int c);
    in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_plot = 1'b1;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst_plot", int'(vga_plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_full", int'(full), 0);
    check("rst_x", int'(vga_x), 0);

    // Pass-through
    vga_ready = 1'b1;
    pix(10, 20, 3); step(); in_plot = 1'b0;
    check("pt_x", int'(vga_x), 10);
    check("pt_y", int'(vga_y), 20);
    check("pt_col", int'(vga_colour), 3);
    check("pt_plot", int'(vga_plot), 1);
    step();
    check("pt_empty", int'(vga_plot), 0);

    // Clipping
    vga_ready = 1'b0;
    pix(160, 0, 1); step();
    pix(0, 120, 2); step();
    pix(255, 127, 4); step();
    in_plot = 1'b0; step();
    check("clip3", int'(clip_count), 3);
    check("clip_noplot", int'(vga_plot), 0);

    // Overflow
    for (int i = 0; i < 10; i++) begin
      pix(i + 1, i + 2, i % 8); step();
      if (i == 7) check("ovf_full8", int'(full), 1);
    end
    in_plot = 1'b0; step();
    check("ovf_drop", int'(drop_count), 2);
    check("ovf_head", int'(vga_x), 1);

    // Push and pop together while full
    vga_ready = 1'b1; pix(100, 100, 5); step(); in_plot = 1'b0;
    check("pp_drop", int'(drop_count), 2);
    check("pp_full", int'(full), 1);
    check("pp_head", int'(vga_x), 2);
    step();
    check("pop_full_off", int'(full), 0);
    for (int i = 0; i < 8; i++) step();
    check("drained", int'(vga_plot), 0);

    // Reset mid-stream
    vga_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin pix(30 + i, 40, 1); step(); end
    in_plot = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
    check("mrst_plot", int'(vga_plot), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_clip", int'(clip_count), 0);
    check("mrst_drop", int'(drop_count), 0);

    // Done re-timing
    for (int i = 0; i < 4; i++) begin pix(50 + i, 60, 2); step(); end
    in_plot = 1'b0; in_done = 1'b1; step(); in_done = 1'b0;
    check("dn_wait", int'(done), 0);
    for (int k = 0; k < 8; k++) begin vga_ready = (k % 2 == 0); step(); end
    vga_ready = 1'b0;
    check("dn_plot", int'(vga_plot), 0);
    step();
    check("dn_high", int'(done), 1);
    clear = 1'b1; step(); clear = 1'b0;
    check("dn_clear", int'(done), 0);

    // Clip counter saturation
    for (int i = 0; i < 260; i++) begin pix(200, 10, 0); step(); end
    in_plot = 1'b0; step();
    check("clip_sat", int'(clip_count), 255);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/plot_fifo.md
# plot_fifo

Pixel-stream buffer and clipper between the drawing engines (circle, reuleaux, fillscreen) and the VGA adapter's pixel write port. It accepts one plot request per cycle and discards any pixel outside the 160x120 screen. Surviving pixels are buffered in a small FIFO and released to the adapter under a valid/ready handshake. It re-times the engine's `done` so that `done` asserts only after every buffered pixel has been written.

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous flush: empties the FIFO and zeroes the counters and the done tracking.
- in_x  input  8  pixel x from the drawing engine.
- in_y  input  7  pixel y from the drawing engine.
- in_colour  input  3  pixel colour.
- in_plot  input  1  pixel request; the engine does not stall, so the request is valid for one cycle only.
- in_done  input  1  engine done level.
- vga_x  output  8  x at the FIFO head.
- vga_y  output  7  y at the FIFO head.
- vga_colour  output  3  colour at the FIFO head.
- vga_plot  output  1  head valid; high whenever the FIFO is not empty.
- vga_ready  input  1  adapter accepts the head this cycle.
- done  output  1  engine finished and every buffered pixel written.
- full  output  1  FIFO holds DEPTH entries.
- clip_count  output  8  pixels discarded as off-screen; saturates at 255.
- drop_count  output  8  pixels lost to overflow; saturates at 255.

## Operation
- Clip: a request is on-screen iff in_x < 160 and in_y < 120, compared unsigned. An off-screen request with in_plot=1 increments clip_count and is not stored.
- Push: an on-screen request with in_plot=1 is written at the write pointer if a slot is free. A slot is free when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle.
- Overflow: if no slot is free, the request is discarded and drop_count increments. The FIFO contents are unchanged.
- Pop: occurs when vga_plot && vga_ready. The read pointer advances.
- vga_ready while the FIFO is empty has no effect.
- Head outputs are read from storage at the read pointer (show-ahead). While vga_plot=0 they hold 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter of log2(DEPTH)+1 bits.
- Done tracking:
  - done_seen sets on any cycle with in_done=1 and stays set until clear or reset.
  - done = done_seen && count==0 && in_plot==0, registered.
- States:
  - EMPTY: count==0.
  - FILLING: 0<count<DEPTH.
  - FULL: count==DEPTH.
  - Transitions follow the push/pop rules above. A simultaneous push and pop leaves the state unchanged.
- Clear: when clear=1, count, both pointers, both counters, done_seen and done go to 0. Any request or pop in that cycle is ignored. clear has priority over all other activity.
- Reset: when rst_n=0 on a clock edge, the effect is the same as clear, and it has priority over clear. Reset asserted mid-stream discards all buffered pixels.

## Timing
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, done=0, full=0, clip_count=0, drop_count=0.
- Latency: a pixel pushed at edge N into an empty FIFO drives vga_plot=1 from just after edge N. It can be popped at edge N+1, so the minimum input-to-write latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained indefinitely while vga_ready=1.
- full and vga_plot are registered state, not combinational from in_plot.
- done rises on the edge after the last pop, provided done_seen is set. done falls only on clear or reset.
- Counters update on the edge following the discarding request and saturate at 255 without wrapping.

## Test plan
- Reset mid-stream: buffer 5 pixels, assert rst_n=0 for 1 cycle -> the next cycle shows vga_plot=0, done=0 and both counters at 0.
- Pass-through: push (10,20,colour 3) with vga_ready=1 -> the next cycle shows vga_x=10, vga_y=20, vga_colour=3, vga_plot=1, and the FIFO is empty one cycle later.
- Clip: push (160,0), (0,120) and (255,127) -> clip_count=3, and vga_plot never asserts.
- Overflow at DEPTH=8: hold vga_ready=0 and push 10 pixels -> full=1 after the 8th, drop_count=2. Then release vga_ready -> exactly the first 8 pixels appear in order, and full deasserts after the first pop.
- Simultaneous push and pop when full: with count=8, push and pop in the same cycle -> drop_count is unchanged and count stays 8.
- Done re-timing: raise in_done with 4 pixels buffered and vga_ready toggling 1,0,1,0... -> done stays 0 until the cycle after the 4th pop, then 1. Asserting clear then returns done to 0.
